// File: rtl/serial_link_pkg.sv
// Shared types and width helpers for the serial-link virtual-channel arbiter.
package serial_link_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } vc_arb_state_e;

    // Counter must represent NumCredits itself, hence the +1.
    function automatic int unsigned credit_width(input int unsigned num_credits);
        return $clog2(num_credits + 1);
    endfunction

    function automatic int unsigned vc_id_width(input int unsigned num_vc);
        return (num_vc > 1) ? $clog2(num_vc) : 1;
    endfunction

endpackage

// File: rtl/serial_link_vc_credit_cnt.sv
// Per-VC credit counter mirroring the free slots of the far-side receive queue.
module serial_link_vc_credit_cnt
    import serial_link_pkg::*;
#(
    parameter int unsigned NumCredits = 8,
    parameter type credit_t = logic [credit_width(NumCredits)-1:0]
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    dec_i,
    input  logic    inc_i,
    input  credit_t inc_num_i,
    output credit_t count_o,
    output logic    nonzero_o
);

    localparam int unsigned CW = $bits(credit_t);
    localparam credit_t ResetCount = credit_t'(NumCredits);
    localparam logic [CW:0] MaxCount = (CW + 1)'(NumCredits);

    credit_t        count_q;
    credit_t        count_d;
    logic    [CW:0] count_d_wide;

    // One extra bit so overflow past NumCredits and underflow are observable.
    always_comb begin
        count_d_wide = {1'b0, count_q} - {{CW{1'b0}}, dec_i}
                     + (inc_i ? {1'b0, inc_num_i} : '0);
        count_d      = count_d_wide[CW-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= ResetCount;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign nonzero_o = |count_q;

    credit_underflow_a : assert property (
        @(posedge clk_i) disable iff (!rst_ni) dec_i |-> (count_q != '0)
    );

    credit_overflow_a : assert property (
        @(posedge clk_i) disable iff (!rst_ni) (dec_i | inc_i) |-> (count_d_wide <= MaxCount)
    );

endmodule

// File: rtl/serial_link_vc_arbiter.sv
// Credit-aware round-robin arbiter sharing one serial-link transmit stream among NumVc VCs.
module serial_link_vc_arbiter
    import serial_link_pkg::*;
#(
    parameter int unsigned NumVc      = 4,
    parameter int unsigned NumCredits = 8,
    parameter type data_t   = logic,
    parameter type credit_t = logic [credit_width(NumCredits)-1:0],
    parameter type vc_id_t  = logic [vc_id_width(NumVc)-1:0]
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic    [NumVc-1:0]    req_valid_i,
    output logic    [NumVc-1:0]    req_ready_o,
    input  data_t   [NumVc-1:0]    req_data_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output data_t                  out_data_o,
    output vc_id_t                 out_vc_o,
    input  logic                   credit_valid_i,
    input  vc_id_t                 credit_vc_i,
    input  credit_t                credit_num_i,
    output credit_t [NumVc-1:0]    credits_o
);

    localparam int unsigned IW = $bits(vc_id_t);
    localparam logic [IW:0] NumVcW = (IW + 1)'(NumVc);

    vc_arb_state_e state_q;
    vc_id_t        lock_vc_q;
    vc_id_t        prio_q;

    logic [NumVc-1:0]   nonzero;
    logic [NumVc-1:0]   elig;
    logic [NumVc-1:0]   credit_ret;
    logic [NumVc-1:0]   hs_vec;
    logic [2*NumVc-1:0] elig_rot_wide;
    logic [NumVc-1:0]   elig_rot;
    vc_id_t             rot_off;
    logic [IW:0]        arb_sum;
    vc_id_t             arb_vc;
    vc_id_t             grant_vc;
    logic [IW:0]        prio_sum;
    vc_id_t             prio_next;
    logic               any_elig;
    logic               hs;

    for (genvar gi = 0; gi < NumVc; gi++) begin : g_vc
        assign elig[gi]        = req_valid_i[gi] & nonzero[gi];
        assign credit_ret[gi]  = credit_valid_i & (credit_vc_i == vc_id_t'(gi));
        assign hs_vec[gi]      = hs & (grant_vc == vc_id_t'(gi));
        assign req_ready_o[gi] = hs_vec[gi];

        serial_link_vc_credit_cnt #(
            .NumCredits (NumCredits),
            .credit_t   (credit_t)
        ) u_credit_cnt (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .dec_i      (hs_vec[gi]),
            .inc_i      (credit_ret[gi]),
            .inc_num_i  (credit_num_i),
            .count_o    (credits_o[gi]),
            .nonzero_o  (nonzero[gi])
        );
    end

    // Rotate eligibility so prio_q lands on bit 0, pick the lowest set bit, then undo the rotation.
    always_comb begin
        elig_rot_wide = {elig, elig} >> prio_q;
        elig_rot      = elig_rot_wide[NumVc-1:0];
        rot_off       = '0;
        for (int i = NumVc - 1; i >= 0; i--) begin
            if (elig_rot[i]) begin
                rot_off = vc_id_t'(i);
            end
        end
        arb_sum = {1'b0, prio_q} + {1'b0, rot_off};
        if (arb_sum >= NumVcW) begin
            arb_sum = arb_sum - NumVcW;
        end
        arb_vc = vc_id_t'(arb_sum);
    end

    assign any_elig    = |elig;
    assign grant_vc    = (state_q == LOCK) ? lock_vc_q : arb_vc;
    assign out_valid_o = (state_q == LOCK) | any_elig;
    assign out_vc_o    = grant_vc;
    assign out_data_o  = req_data_i[grant_vc];
    assign hs          = out_valid_o & out_ready_i;

    always_comb begin
        prio_sum = {1'b0, grant_vc} + {{IW{1'b0}}, 1'b1};
        if (prio_sum >= NumVcW) begin
            prio_sum = '0;
        end
        prio_next = vc_id_t'(prio_sum);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ARB;
            lock_vc_q <= '0;
            prio_q    <= '0;
        end else begin
            if (hs) begin
                prio_q <= prio_next;
            end
            case (state_q)
                ARB: begin
                    if (out_valid_o && !out_ready_i) begin
                        state_q   <= LOCK;
                        lock_vc_q <= arb_vc;
                    end
                end
                LOCK: begin
                    if (out_ready_i) begin
                        state_q <= ARB;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    // A locked VC was granted with credits and only its own handshake can consume them.
    lock_has_credit_a : assert property (
        @(posedge clk_i) disable iff (!rst_ni) (state_q == LOCK) |-> nonzero[lock_vc_q]
    );

endmodule

// File: tb/tb_serial_link_vc_arbiter.sv
// Directed bench for serial_link_vc_arbiter: reset, round robin, credits, lock, async reset.
module tb_serial_link_vc_arbiter;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [3:0]      req_valid;
    logic [3:0]      req_ready;
    logic [3:0][7:0] req_data;
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      out_data;
    logic [1:0]      out_vc;
    logic            credit_valid;
    logic [1:0]      credit_vc;
    logic [3:0]      credit_num;
    logic [3:0][3:0] credits;

    int n_cmp = 0;
    int n_err = 0;

    serial_link_vc_arbiter #(
        .NumVc      (4),
        .NumCredits (8),
        .data_t     (logic [7:0])
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_data_i     (req_data),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_data_o     (out_data),
        .out_vc_o       (out_vc),
        .credit_valid_i (credit_valid),
        .credit_vc_i    (credit_vc),
        .credit_num_i   (credit_num),
        .credits_o      (credits)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset;
        rst_ni       = 1'b0;
        req_valid    = '0;
        out_ready    = 1'b0;
        credit_valid = 1'b0;
        credit_vc    = '0;
        credit_num   = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (credits[k] !== 4'd8) begin n_err++; $display("FAIL reset_credits[%0d]: got %0d want 8", k, credits[k]); end
        end
        $display("reset: out_valid=%0b credits=%h", out_valid, credits);
    endtask

    task automatic test_round_robin;
        logic [1:0] e;
        do_reset();
        req_valid = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            e = 2'(i % 4);
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rr_valid beat %0d: got %0b want 1", i, out_valid); end
            n_cmp++; if (out_vc !== e) begin n_err++; $display("FAIL rr_vc beat %0d: got %0d want %0d", i, out_vc, e); end
            n_cmp++; if (out_data !== 8'hA0 + 8'(e)) begin n_err++; $display("FAIL rr_data beat %0d: got %h want %h", i, out_data, 8'hA0 + 8'(e)); end
            n_cmp++; if (req_ready !== (4'b0001 << e)) begin n_err++; $display("FAIL rr_ready beat %0d: got %b want %b", i, req_ready, 4'b0001 << e); end
            $display("rr beat %0d: vc=%0d data=%h", i, out_vc, out_data);
            tick();
        end
        req_valid = '0;
        #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (credits[k] !== 4'd6) begin n_err++; $display("FAIL rr_credits[%0d]: got %0d want 6", k, credits[k]); end
        end
    endtask

    task automatic test_credit_exhaustion;
        do_reset();
        req_valid = 4'b0010;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL exh_valid beat %0d: got %0b want 1", i, out_valid); end
            n_cmp++; if (out_vc !== 2'd1) begin n_err++; $display("FAIL exh_vc beat %0d: got %0d want 1", i, out_vc); end
            $display("exh beat %0d: vc=%0d credits=%0d", i, out_vc, credits[1]);
            tick();
        end
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL exh_blocked: got %0b want 0", out_valid); end
        n_cmp++; if (credits[1] !== 4'd0) begin n_err++; $display("FAIL exh_zero: got %0d want 0", credits[1]); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL exh_ready_blocked: got %b want 0000", req_ready); end
        credit_valid = 1'b1;
        credit_vc    = 2'd1;
        credit_num   = 4'd3;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL exh_ret_cycle: got %0b want 0", out_valid); end
        $display("exh credit return: vc=1 num=3");
        tick();
        credit_valid = 1'b0;
        credit_num   = '0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++; if (out_valid !== (c < 3)) begin n_err++; $display("FAIL exh_refill cyc %0d: got %0b want %0b", c, out_valid, c < 3); end
            n_cmp++; if (req_ready !== ((c < 3) ? 4'b0010 : 4'b0000)) begin n_err++; $display("FAIL exh_refill_ready cyc %0d: got %b", c, req_ready); end
            $display("exh refill cyc %0d: valid=%0b vc=%0d", c, out_valid, out_vc);
            tick();
        end
        #1;
        n_cmp++; if (credits[1] !== 4'd0) begin n_err++; $display("FAIL exh_final: got %0d want 0", credits[1]); end
        req_valid = '0;
    endtask

    task automatic test_backpressure;
        do_reset();
        req_valid = 4'b0101;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid cyc %0d: got %0b want 1", i, out_valid); end
            n_cmp++; if (out_vc !== 2'd0) begin n_err++; $display("FAIL bp_vc cyc %0d: got %0d want 0", i, out_vc); end
            n_cmp++; if (out_data !== 8'hA0) begin n_err++; $display("FAIL bp_data cyc %0d: got %h want a0", i, out_data); end
            n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready cyc %0d: got %b want 0000", i, req_ready); end
            $display("bp stall %0d: vc=%0d data=%h", i, out_vc, out_data);
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (out_vc !== 2'd0) begin n_err++; $display("FAIL bp_accept_vc: got %0d want 0", out_vc); end
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL bp_accept_ready: got %b want 0001", req_ready); end
        $display("bp accept: vc=%0d", out_vc);
        tick();
        #1;
        n_cmp++; if (out_vc !== 2'd2) begin n_err++; $display("FAIL bp_next_vc: got %0d want 2", out_vc); end
        n_cmp++; if (out_data !== 8'hA2) begin n_err++; $display("FAIL bp_next_data: got %h want a2", out_data); end
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL bp_next_ready: got %b want 0100", req_ready); end
        $display("bp next: vc=%0d", out_vc);
        tick();
        req_valid = '0;
        out_ready = 1'b0;
    endtask

    task automatic test_simultaneous;
        do_reset();
        req_valid = 4'b0100;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        #1;
        n_cmp++; if (credits[2] !== 4'd1) begin n_err++; $display("FAIL sim_pre: got %0d want 1", credits[2]); end
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL sim_hs: got %b want 0100", req_ready); end
        credit_valid = 1'b1;
        credit_vc    = 2'd2;
        credit_num   = 4'd2;
        $display("sim: handshake and return 2 on vc2");
        tick();
        credit_valid = 1'b0;
        credit_num   = '0;
        req_valid    = '0;
        #1;
        n_cmp++; if (credits[2] !== 4'd2) begin n_err++; $display("FAIL sim_net: got %0d want 2", credits[2]); end
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset;
        do_reset();
        req_valid = 4'b0010;
        out_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL ar_first_hs: got %b want 0010", req_ready); end
        tick();
        req_valid = 4'b1010;
        out_ready = 1'b0;
        #1;
        n_cmp++; if (out_vc !== 2'd3) begin n_err++; $display("FAIL ar_grant: got %0d want 3", out_vc); end
        tick();
        #1;
        n_cmp++; if (credits[1] !== 4'd7) begin n_err++; $display("FAIL ar_pre_credit: got %0d want 7", credits[1]); end
        n_cmp++; if (out_vc !== 2'd3) begin n_err++; $display("FAIL ar_locked_vc: got %0d want 3", out_vc); end
        req_valid = '0;
        rst_ni    = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ar_valid: got %0b want 0", out_valid); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL ar_ready: got %b want 0000", req_ready); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (credits[k] !== 4'd8) begin n_err++; $display("FAIL ar_credits[%0d]: got %0d want 8", k, credits[k]); end
        end
        $display("async reset applied: out_valid=%0b credits=%h", out_valid, credits);
        #1;
        rst_ni    = 1'b1;
        req_valid = 4'b1010;
        out_ready = 1'b1;
        #1;
        n_cmp++; if (out_vc !== 2'd1) begin n_err++; $display("FAIL ar_restart_vc: got %0d want 1", out_vc); end
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL ar_restart_ready: got %b want 0010", req_ready); end
        $display("async reset restart: vc=%0d", out_vc);
        tick();
        req_valid = '0;
        out_ready = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            req_data[k] = 8'hA0 + 8'(k);
        end
        test_reset();
        test_round_robin();
        test_credit_exhaustion();
        test_backpressure();
        test_simultaneous();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
